// File: rtl/if_stage_pkg.sv
// Shared widths, constants and types for the instruction-fetch stage and its IF/ID register.
package if_stage_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] ZERO_ADDR    = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] PC_INCR      = 32'h0000_0004;
    localparam logic                   CHIP_ENABLE  = 1'b1;
    localparam logic                   CHIP_DISABLE = 1'b0;
    localparam logic                   RST_ENABLE   = 1'b0;

    typedef enum logic [2:0] {
        PC_SEL_RESET  = 3'd0,
        PC_SEL_FLUSH  = 3'd1,
        PC_SEL_HOLD   = 3'd2,
        PC_SEL_BRANCH = 3'd3,
        PC_SEL_SEQ    = 3'd4
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_CLEAR  = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2,
        IFID_LOAD   = 2'd3
    } ifid_op_e;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
        logic                   valid;
        logic                   adel;
    } if_id_t;

    localparam if_id_t IF_ID_CLEAR = '{pc: ZERO_ADDR, inst: ZERO_WORD, valid: 1'b0, adel: 1'b0};

    // Instruction fetches must be word aligned.
    function automatic logic addr_misaligned(input logic [INST_ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures {pc, inst} from fetch with flush, stall and bubble handling.
module if_stage_if_id_reg
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   stall_pc_i,
    input  logic                   stall_id_i,
    input  logic                   ce_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   id_valid_o,
    output logic                   id_adel_o
);

    if_id_t   ifid_q;
    if_id_t   ifid_d;
    ifid_op_e op_s;
    logic     adel_s;

    // Select the register action; flush beats stall, ID stall beats IF stall.
    always_comb begin
        op_s = IFID_LOAD;
        if (flush_i) begin
            op_s = IFID_CLEAR;
        end else if (stall_id_i) begin
            op_s = IFID_HOLD;
        end else if (stall_pc_i) begin
            op_s = IFID_BUBBLE;
        end else begin
            op_s = IFID_LOAD;
        end
    end

    // Build the next register contents; a misaligned fetch is captured as a zero word.
    always_comb begin
        ifid_d = ifid_q;
        adel_s = ce_i & addr_misaligned(pc_i);
        case (op_s)
            IFID_CLEAR: begin
                ifid_d = IF_ID_CLEAR;
            end
            IFID_HOLD: begin
                ifid_d = ifid_q;
            end
            IFID_BUBBLE: begin
                ifid_d.inst  = ZERO_WORD;
                ifid_d.valid = 1'b0;
                ifid_d.adel  = 1'b0;
            end
            IFID_LOAD: begin
                ifid_d.pc    = pc_i;
                ifid_d.inst  = adel_s ? ZERO_WORD : inst_i;
                ifid_d.valid = ce_i;
                ifid_d.adel  = adel_s;
            end
            default: begin
                ifid_d = IF_ID_CLEAR;
            end
        endcase
    end

    // IF/ID state register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            ifid_q <= IF_ID_CLEAR;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign id_pc_o    = ifid_q.pc;
    assign id_inst_o  = ifid_q.inst;
    assign id_valid_o = ifid_q.valid;
    assign id_adel_o  = ifid_q.adel;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and ROM chip enable, feeds the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_pc_i,
    input  logic                   stall_id_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] new_pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic                   ce_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   id_valid_o,
    output logic                   id_adel_o
);

    logic                   ce_q;
    logic                   ce_d;
    logic [INST_ADDR_W-1:0] pc_q;
    logic [INST_ADDR_W-1:0] pc_d;
    pc_sel_e                pc_sel_s;

    // Chip enable rises on the first edge after reset and stays high.
    always_comb begin
        ce_d = CHIP_ENABLE;
    end

    // PC source priority; an ID stall also freezes the PC so no fetch is lost.
    always_comb begin
        pc_sel_s = PC_SEL_SEQ;
        if (ce_q == CHIP_DISABLE) begin
            pc_sel_s = PC_SEL_RESET;
        end else if (flush_i) begin
            pc_sel_s = PC_SEL_FLUSH;
        end else if (stall_pc_i | stall_id_i) begin
            pc_sel_s = PC_SEL_HOLD;
        end else if (branch_flag_i) begin
            pc_sel_s = PC_SEL_BRANCH;
        end else begin
            pc_sel_s = PC_SEL_SEQ;
        end
    end

    // Next PC; sequential increment wraps naturally modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel_s)
            PC_SEL_RESET:  pc_d = RESET_PC;
            PC_SEL_FLUSH:  pc_d = new_pc_i;
            PC_SEL_HOLD:   pc_d = pc_q;
            PC_SEL_BRANCH: pc_d = branch_target_i;
            PC_SEL_SEQ:    pc_d = pc_q + PC_INCR;
            default:       pc_d = RESET_PC;
        endcase
    end

    // PC and chip-enable registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            ce_q <= CHIP_DISABLE;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= ce_d;
            pc_q <= pc_d;
        end
    end

    assign ce_o = ce_q;
    assign pc_o = pc_q;

    if_stage_if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .stall_pc_i (stall_pc_i),
        .stall_id_i (stall_id_i),
        .ce_i       (ce_q),
        .pc_i       (pc_q),
        .inst_i     (inst_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o),
        .id_adel_o  (id_adel_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the ROM model returns pc + 0x1000_0000 as the instruction word.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_pc_i;
    logic        stall_id_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [31:0] inst_i;
    logic        ce_o;
    logic [31:0] pc_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;

    int n_tests;
    int n_fail;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_pc_i      (stall_pc_i),
        .stall_id_i      (stall_id_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .inst_i          (inst_i),
        .ce_o            (ce_o),
        .pc_o            (pc_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_adel_o       (id_adel_o)
    );

    assign inst_i = pc_o + 32'h1000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid, input logic adel);
        check_val({tag, ".id_pc"},    id_pc_o,           pc);
        check_val({tag, ".id_inst"},  id_inst_o,         inst);
        check_val({tag, ".id_valid"}, {31'd0, id_valid_o}, {31'd0, valid});
        check_val({tag, ".id_adel"},  {31'd0, id_adel_o},  {31'd0, adel});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        stall_pc_i = 1'b0;
        stall_id_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0000_0000;
        flush_i = 1'b0;
        new_pc_i = 32'h0000_0000;
        #1;
        check_val("rst.ce", {31'd0, ce_o}, 32'd0);
        check_val("rst.pc", pc_o, 32'h0000_0000);
        check_id("rst", 32'h0, 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        cyc(); // first edge: ce rises, pc stays at reset value
        check_val("e1.ce", {31'd0, ce_o}, 32'd1);
        check_val("e1.pc", pc_o, 32'h0000_0000);
        check_val("e1.id_valid", {31'd0, id_valid_o}, 32'd0);
        cyc();
        check_val("e2.pc", pc_o, 32'h0000_0004);
        check_id("e2", 32'h0000_0000, 32'h1000_0000, 1'b1, 1'b0);
        cyc();
        check_val("e3.pc", pc_o, 32'h0000_0008);
        check_id("e3", 32'h0000_0004, 32'h1000_0004, 1'b1, 1'b0);

        // Taken branch at pc 0x8: delay slot captured, target fetched next
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0100;
        cyc();
        branch_flag_i = 1'b0;
        check_val("br.pc", pc_o, 32'h0000_0100);
        check_id("br.slot", 32'h0000_0008, 32'h1000_0008, 1'b1, 1'b0);
        cyc();
        check_val("br2.pc", pc_o, 32'h0000_0104);
        check_id("br2", 32'h0000_0100, 32'h1000_0100, 1'b1, 1'b0);

        // Redirect to 0x10, then stall IF for two cycles (stall beats branch)
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0010;
        cyc();
        flush_i = 1'b0;
        check_val("fl10.pc", pc_o, 32'h0000_0010);
        check_id("fl10", 32'h0, 32'h0, 1'b0, 1'b0);
        stall_pc_i = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0300;
        cyc();
        check_val("spc1.pc", pc_o, 32'h0000_0010);
        check_id("spc1", 32'h0, 32'h0, 1'b0, 1'b0);
        branch_flag_i = 1'b0;
        cyc();
        check_val("spc2.pc", pc_o, 32'h0000_0010);
        check_id("spc2", 32'h0, 32'h0, 1'b0, 1'b0);
        stall_pc_i = 1'b0;
        cyc();
        check_val("spc3.pc", pc_o, 32'h0000_0014);
        check_id("spc3", 32'h0000_0010, 32'h1000_0010, 1'b1, 1'b0);

        // Flush with ID stall: flush wins
        stall_id_i = 1'b1;
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0020;
        cyc();
        flush_i = 1'b0;
        stall_id_i = 1'b0;
        check_val("fsid.pc", pc_o, 32'h0000_0020);
        check_id("fsid", 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        check_val("n24.pc", pc_o, 32'h0000_0024);
        check_id("n24", 32'h0000_0020, 32'h1000_0020, 1'b1, 1'b0);

        // ID stall alone holds IF/ID and PC, even over a branch
        stall_id_i = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0200;
        cyc();
        stall_id_i = 1'b0;
        branch_flag_i = 1'b0;
        check_val("sid.pc", pc_o, 32'h0000_0024);
        check_id("sid", 32'h0000_0020, 32'h1000_0020, 1'b1, 1'b0);

        // Misaligned redirect
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0022;
        cyc();
        flush_i = 1'b0;
        check_val("mis.pc", pc_o, 32'h0000_0022);
        cyc();
        check_val("mis.ce", {31'd0, ce_o}, 32'd1);
        check_val("mis2.pc", pc_o, 32'h0000_0026);
        check_id("mis", 32'h0000_0022, 32'h0, 1'b1, 1'b1);

        // PC wrap at top of address space
        flush_i = 1'b1;
        new_pc_i = 32'hFFFF_FFFC;
        cyc();
        flush_i = 1'b0;
        check_val("wrap0.pc", pc_o, 32'hFFFF_FFFC);
        cyc();
        check_val("wrap1.pc", pc_o, 32'h0000_0000);
        check_id("wrap1", 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b1, 1'b0);
        cyc();
        check_val("wrap2.pc", pc_o, 32'h0000_0004);
        check_id("wrap2", 32'h0000_0000, 32'h1000_0000, 1'b1, 1'b0);

        // Asynchronous reset mid-stream at pc 0x40, between clock edges
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0040;
        cyc();
        flush_i = 1'b0;
        cyc();
        check_val("pre.pc", pc_o, 32'h0000_0044);
        check_id("pre", 32'h0000_0040, 32'h1000_0040, 1'b1, 1'b0);
        stall_pc_i = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_val("arst.ce", {31'd0, ce_o}, 32'd0);
        check_val("arst.pc", pc_o, 32'h0000_0000);
        check_id("arst", 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        check_val("arst2.ce", {31'd0, ce_o}, 32'd0);
        check_val("arst2.pc", pc_o, 32'h0000_0000);
        stall_pc_i = 1'b0;
        rst = 1'b1;
        cyc();
        check_val("rel.ce", {31'd0, ce_o}, 32'd1);
        check_val("rel.pc", pc_o, 32'h0000_0000);
        cyc();
        check_val("rel2.pc", pc_o, 32'h0000_0004);
        check_id("rel2", 32'h0000_0000, 32'h1000_0000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
